// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry skid buffer between fetch and execute.
// Optional RVC decode is enabled by defining IMMGEN_RVC_EN.
module imm_gen_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FmtNone  = 3'd0;
    localparam logic [2:0] FmtI     = 3'd1;
    localparam logic [2:0] FmtS     = 3'd2;
    localparam logic [2:0] FmtB     = 3'd3;
    localparam logic [2:0] FmtU     = 3'd4;
    localparam logic [2:0] FmtJ     = 3'd5;
    localparam logic [2:0] FmtShamt = 3'd6;
`ifdef IMMGEN_RVC_EN
    localparam logic [2:0] FmtCmp   = 3'd7;
`endif

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t dec_entry;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;

    logic load_out;
    logic load_skid;
    logic move_skid;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Immediate decode of the word currently on the input port.
    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FmtNone;
        dec_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
`ifdef IMMGEN_RVC_EN
            dec_fmt = FmtCmp;
            case ({in_instr[1:0], in_instr[15:13]})
                5'b01_000, 5'b01_010: begin
                    dec_imm = XLEN'($signed({in_instr[12], in_instr[6:2]}));
                end
                5'b01_101: begin
                    dec_imm = XLEN'($signed({in_instr[12], in_instr[8], in_instr[10:9],
                                             in_instr[6], in_instr[7], in_instr[2],
                                             in_instr[11], in_instr[5:3], 1'b0}));
                end
                5'b01_110, 5'b01_111: begin
                    dec_imm = XLEN'($signed({in_instr[12], in_instr[6:5], in_instr[2],
                                             in_instr[11:10], in_instr[4:3], 1'b0}));
                end
                5'b00_010, 5'b00_110: begin
                    dec_imm = XLEN'({in_instr[5], in_instr[12:10], in_instr[6], 2'b00});
                end
                default: begin
                    dec_fmt     = FmtNone;
                    dec_illegal = 1'b1;
                end
            endcase
`else
            dec_illegal = 1'b1;
`endif
        end else begin
            case (opcode)
                7'b0000011, 7'b1100111, 7'b1110011: begin
                    dec_fmt = FmtI;
                    dec_imm = XLEN'($signed(in_instr[31:20]));
                end
                7'b0010011: begin
                    if (is_shift) begin
                        dec_fmt = FmtShamt;
                        // RV64 shifts use a 6-bit shamt on the full-width opcode.
                        if (XLEN == 64) dec_imm = XLEN'(in_instr[25:20]);
                        else            dec_imm = XLEN'(in_instr[24:20]);
                    end else begin
                        dec_fmt = FmtI;
                        dec_imm = XLEN'($signed(in_instr[31:20]));
                    end
                end
                7'b0011011: begin
                    if (XLEN == 64) begin
                        if (is_shift) begin
                            dec_fmt = FmtShamt;
                            dec_imm = XLEN'(in_instr[24:20]);
                        end else begin
                            dec_fmt = FmtI;
                            dec_imm = XLEN'($signed(in_instr[31:20]));
                        end
                    end
                end
                7'b0100011: begin
                    dec_fmt = FmtS;
                    dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                end
                7'b1100011: begin
                    dec_fmt = FmtB;
                    dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                             in_instr[11:8], 1'b0}));
                end
                7'b0110111, 7'b0010111: begin
                    dec_fmt = FmtU;
                    dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
                end
                7'b1101111: begin
                    dec_fmt = FmtJ;
                    dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                             in_instr[30:21], 1'b0}));
                end
                default: begin
                    dec_fmt = FmtNone;
                end
            endcase
        end
    end

    always_comb begin
        dec_entry         = '0;
        dec_entry.instr   = in_instr;
        dec_entry.pc      = in_pc;
        dec_entry.imm     = dec_imm;
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // flush beats every transfer; the out register holds the head entry, skid the second.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (in_valid) state_d = StOne;
                StOne: begin
                    if (in_valid && !out_ready)      state_d = StFull;
                    else if (!in_valid && out_ready) state_d = StEmpty;
                end
                StFull:  if (out_ready) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != StFull);
        out_valid = (state_q != StEmpty);
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (!flush) begin
            unique case (state_q)
                StEmpty: load_out = in_valid;
                StOne: begin
                    load_out  = in_valid && out_ready;
                    load_skid = in_valid && !out_ready;
                end
                StFull:  move_skid = out_ready;
                default: ;
            endcase
        end
    end

    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (load_out)       out_d = dec_entry;
        else if (move_skid) out_d = skid_q;
        if (load_skid)      skid_d = dec_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    assign out_instr   = out_q.instr;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign out_target  = out_q.pc + out_q.imm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vector table, handshake corner sequences,
// and randomized traffic against a capacity-2 FIFO reference model.
module tb_imm_gen_pipe;
    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    int n_cmp;
    int n_fail;

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_target (out_target),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            ill;
    } vec_t;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            ill;
    } exp_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode from the encoding rules using signed integer arithmetic.
    function automatic void ref_dec(input logic [31:0] ins, output logic [XLEN-1:0] imm,
                                    output logic [2:0] fmt, output logic ill);
        longint v;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        if (ins[1:0] != 2'b11) begin
`ifdef IMMGEN_RVC_EN
            if (ins[1:0] == 2'b01 && (ins[15:13] == 3'b000 || ins[15:13] == 3'b010)) begin
                v   = longint'({ins[12], ins[6:2]});
                if (v >= 32) v = v - 64;
                fmt = 3'd7;
            end else begin
                ill = 1'b1;
            end
`else
            ill = 1'b1;
`endif
        end else begin
            case (ins[6:0])
                7'b0000011, 7'b1100111, 7'b1110011: begin
                    fmt = 3'd1;
                    v   = longint'(ins[31:20]);
                    if (v >= 2048) v = v - 4096;
                end
                7'b0010011: begin
                    if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
                        fmt = 3'd6;
                        v   = (XLEN == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                    end else begin
                        fmt = 3'd1;
                        v   = longint'(ins[31:20]);
                        if (v >= 2048) v = v - 4096;
                    end
                end
                7'b0100011: begin
                    fmt = 3'd2;
                    v   = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                    if (v >= 2048) v = v - 4096;
                end
                7'b1100011: begin
                    fmt = 3'd3;
                    v   = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                        + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                    if (v >= 4096) v = v - 8192;
                end
                7'b0110111, 7'b0010111: begin
                    fmt = 3'd4;
                    v   = longint'(ins[31:12]) * 4096;
                    if (ins[31]) v = v - 64'sh1_0000_0000;
                end
                7'b1101111: begin
                    fmt = 3'd5;
                    v   = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096
                        + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                    if (ins[31]) v = v - (64'sd1 << 21);
                end
                default: fmt = 3'd0;
            endcase
        end
        imm = v[XLEN-1:0];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [11];
        ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 10)];
`ifndef IMMGEN_RVC_EN
        if ($urandom_range(0, 9) == 0) r[1:0] = 2'($urandom_range(0, 2));
`endif
        return r;
    endfunction

    task automatic chk_out(input string nm, input logic [31:0] instr, input logic [XLEN-1:0] imm,
                           input logic [2:0] fmt, input logic [XLEN-1:0] tgt, input logic ill);
        chk({nm, "_instr"}, 64'(out_instr), 64'(instr));
        chk({nm, "_imm"}, 64'(out_imm), 64'(imm));
        chk({nm, "_fmt"}, 64'(out_fmt), 64'(fmt));
        chk({nm, "_target"}, 64'(out_target), 64'(tgt));
        chk({nm, "_illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    vec_t vecs [11];
    exp_t q [$];

    initial begin
        exp_t e;
        logic acc_in;
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        vecs[0]  = '{32'hFFF00093, 32'h100,      32'hFFFFFFFF, 3'd1, 32'h000000FF, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 32'h200,      32'hFFFFFFFC, 3'd3, 32'h000001FC, 1'b0};
        vecs[2]  = '{32'h4050D093, 32'h300,      32'h5,        3'd6, 32'h305,      1'b0};
        vecs[3]  = '{32'h002081B3, 32'h400,      32'h0,        3'd0, 32'h400,      1'b0};
        vecs[4]  = '{32'h800000B7, 32'h80000010, 32'h80000000, 3'd4, 32'h10,       1'b0};
        vecs[5]  = '{32'hFE112E23, 32'h0,        32'hFFFFFFFC, 3'd2, 32'hFFFFFFFC, 1'b0};
        vecs[6]  = '{32'h0080006F, 32'h1000,     32'h8,        3'd5, 32'h1008,     1'b0};
        vecs[7]  = '{32'h00309093, 32'h10,       32'h3,        3'd6, 32'h13,       1'b0};
        vecs[8]  = '{32'h00001097, 32'h2000,     32'h1000,     3'd4, 32'h3000,     1'b0};
        vecs[9]  = '{32'h7FF00093, 32'h0,        32'h7FF,      3'd1, 32'h7FF,      1'b0};
`ifdef IMMGEN_RVC_EN
        vecs[10] = '{32'h000050FD, 32'h40,       32'hFFFFFFFF, 3'd7, 32'h3F,       1'b0};
`else
        vecs[10] = '{32'h000050FD, 32'h40,       32'h0,        3'd0, 32'h40,       1'b1};
`endif

        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk_out("rst", 32'h0, '0, 3'd0, '0, 1'b0);
        #19 rst_n = 1'b1;
        tick();

        // Directed vectors, streamed back to back at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = vecs[i].pc;
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            tick();
            chk("vec_out_valid", 64'(out_valid), 64'd1);
            chk_out("vec", vecs[i].instr, vecs[i].imm, vecs[i].fmt, vecs[i].target, vecs[i].ill);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: third input refused until the head drains, order preserved.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        chk("bp_rdy0", 64'(in_ready), 64'd1);
        tick();
        in_instr = 32'h00200093;
        chk("bp_rdy1", 64'(in_ready), 64'd1);
        tick();
        in_instr = 32'h00300093;
        chk("bp_rdy2", 64'(in_ready), 64'd0);
        chk("bp_head0", 64'(out_instr), 64'h00100093);
        tick();
        chk("bp_hold_head", 64'(out_instr), 64'h00100093);
        chk("bp_hold_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_second", 64'(out_instr), 64'h00200093);
        chk("bp_rdy_one", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_third", 64'(out_instr), 64'h00300093);
        chk("bp_third_v", 64'(out_valid), 64'd1);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a live input: everything disappears.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00A00093;
        tick();
        in_instr = 32'h00B00093;
        tick();
        flush    = 1'b1;
        in_instr = 32'h00C00093;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_stays_empty", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset mid-stream clears outputs without waiting for a clock.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 32'h100;
        tick();
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk_out("arst", 32'h0, '0, 3'd0, '0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        chk("arst_after", 64'(out_valid), 64'd0);

        // Randomized traffic against a capacity-2 FIFO model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = rand_instr();
            in_pc     = XLEN'({$urandom(), $urandom()});
            chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) chk_out("rnd", q[0].instr, q[0].imm, q[0].fmt, q[0].target, q[0].ill);
            acc_in = in_valid && (q.size() < 2);
            if (flush) begin
                q.delete();
            end else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (acc_in) begin
                    e.instr = in_instr;
                    ref_dec(in_instr, e.imm, e.fmt, e.ill);
                    e.target = in_pc + e.imm;
                    q.push_back(e);
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
